// File: rtl/stack_ctrl_pkg.sv
// Shared encodings and payload types for the stack-pointer port controller.
package stack_ctrl_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned ST_W   = 3;

    localparam logic [OP_W-1:0] OP_PUSH = 2'b00;
    localparam logic [OP_W-1:0] OP_POP  = 2'b01;
    localparam logic [OP_W-1:0] OP_CALL = 2'b10;
    localparam logic [OP_W-1:0] OP_RET  = 2'b11;

    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_RDSP  = 3'd1;
    localparam logic [ST_W-1:0] ST_MEMWR = 3'd2;
    localparam logic [ST_W-1:0] ST_MEMRD = 3'd3;
    localparam logic [ST_W-1:0] ST_WB    = 3'd4;
    localparam logic [ST_W-1:0] ST_ERR   = 3'd5;

    // Command fields latched on accept
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [REG_AW-1:0] rg;
        logic [XLEN-1:0]   pc;
    } cmd_t;

    function automatic logic op_is_push(input logic [OP_W-1:0] op);
        return (op == OP_PUSH) || (op == OP_CALL);
    endfunction

endpackage

// File: rtl/sp_limit_chk.sv
// Combinational stack bound check; compares one bit wider so the limits never wrap.
module sp_limit_chk
    import stack_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] SP_MAX = 32'h0000_03FF,
    parameter logic [XLEN-1:0] SP_MIN = 32'h0000_0000,
    parameter logic [XLEN-1:0] STEP   = 32'h0000_0001
) (
    input  logic [XLEN-1:0] sp,
    input  logic            is_push,
    output logic            limit_err_c
);

    logic [XLEN:0] sp_w;
    logic [XLEN:0] floor_w;
    logic [XLEN:0] ceil_w;

    always_comb begin
        sp_w        = {1'b0, sp};
        floor_w     = {1'b0, SP_MIN} + {1'b0, STEP};
        ceil_w      = {1'b0, SP_MAX};
        limit_err_c = is_push ? (sp_w < floor_w) : (sp_w >= ceil_w);
    end

endmodule

// File: rtl/stack_ctrl.sv
// PUSH/POP/CALL/RET sequencer between the command handshake, the register bank SP port
// and data memory. Strobes are decodes of the registered state so they settle early in the cycle.
module stack_ctrl
    import stack_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] SP_MAX = 32'h0000_03FF,
    parameter logic [XLEN-1:0] SP_MIN = 32'h0000_0000,
    parameter logic [XLEN-1:0] STEP   = 32'h0000_0001
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [REG_AW-1:0] cmd_reg,
    input  logic [XLEN-1:0]   cmd_pc,
    output logic              done,
    output logic              err,
    output logic [XLEN-1:0]   ret_pc,
    output logic              readSP,
    output logic [REG_AW-1:0] sr2,
    input  logic [XLEN-1:0]   read_data1,
    input  logic [XLEN-1:0]   read_data2,
    output logic              writeReg,
    output logic [REG_AW-1:0] dr,
    output logic [XLEN-1:0]   write_data,
    output logic              writeSP,
    output logic [XLEN-1:0]   write_dataSP,
    output logic [XLEN-1:0]   mem_addr,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_wdata,
    output logic              mem_re,
    input  logic [XLEN-1:0]   mem_rdata
);

    logic [ST_W-1:0] state_q, state_d;
    cmd_t            cmd_q, cmd_d;
    logic [XLEN-1:0] sp_q, sp_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [XLEN-1:0] ret_pc_q, ret_pc_d;

    logic            push_c;
    logic            limit_err_c;
    logic [XLEN-1:0] sp_dec_c;
    logic [XLEN-1:0] sp_inc_c;

    assign push_c   = op_is_push(cmd_q.op);
    assign sp_dec_c = sp_q - STEP;
    assign sp_inc_c = sp_q + STEP;

    // Bound check runs on the live SP read during RDSP
    sp_limit_chk #(
        .SP_MAX (SP_MAX),
        .SP_MIN (SP_MIN),
        .STEP   (STEP)
    ) u_limit (
        .sp          (read_data1),
        .is_push     (push_c),
        .limit_err_c (limit_err_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cmd_q    <= '0;
            sp_q     <= '0;
            data_q   <= '0;
            ret_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            sp_q     <= sp_d;
            data_q   <= data_d;
            ret_pc_q <= ret_pc_d;
        end
    end

    // Next state and latch updates
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        sp_d     = sp_q;
        data_d   = data_q;
        ret_pc_d = ret_pc_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cmd_d.op = cmd_op;
                    cmd_d.rg = cmd_reg;
                    cmd_d.pc = cmd_pc;
                    state_d  = ST_RDSP;
                end
            end
            ST_RDSP: begin
                sp_d   = read_data1;
                data_d = (cmd_q.op == OP_CALL) ? cmd_q.pc : read_data2;
                if (limit_err_c) begin
                    state_d = ST_ERR;
                end else if (push_c) begin
                    state_d = ST_MEMWR;
                end else begin
                    state_d = ST_MEMRD;
                end
            end
            ST_MEMWR: state_d = ST_IDLE;
            ST_MEMRD: state_d = ST_WB;
            ST_WB: begin
                if (cmd_q.op == OP_RET) begin
                    ret_pc_d = mem_rdata;
                end
                state_d = ST_IDLE;
            end
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Moore output decode
    always_comb begin
        cmd_ready    = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        readSP       = 1'b0;
        writeReg     = 1'b0;
        write_data   = '0;
        writeSP      = 1'b0;
        write_dataSP = '0;
        mem_addr     = '0;
        mem_we       = 1'b0;
        mem_wdata    = '0;
        mem_re       = 1'b0;
        sr2          = cmd_q.rg;
        dr           = cmd_q.rg;
        ret_pc       = ret_pc_q;
        case (state_q)
            ST_IDLE: cmd_ready = 1'b1;
            ST_RDSP: readSP = 1'b1;
            ST_MEMWR: begin
                mem_we       = 1'b1;
                mem_addr     = sp_dec_c;
                mem_wdata    = data_q;
                writeSP      = 1'b1;
                write_dataSP = sp_dec_c;
                done         = 1'b1;
            end
            ST_MEMRD: begin
                mem_re   = 1'b1;
                mem_addr = sp_q;
            end
            ST_WB: begin
                writeSP      = 1'b1;
                write_dataSP = sp_inc_c;
                done         = 1'b1;
                // r0 is hardwired; the pop still consumes the slot
                if ((cmd_q.op == OP_POP) && (cmd_q.rg != '0)) begin
                    writeReg   = 1'b1;
                    write_data = mem_rdata;
                end
            end
            ST_ERR: begin
                done = 1'b1;
                err  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: behavioural regbank/memory environment, directed vector table,
// reset-abort sequence and randomized ops checked against an abstract stack model.
module tb_stack_ctrl;

    localparam logic [1:0] PUSH = 2'd0;
    localparam logic [1:0] POP  = 2'd1;
    localparam logic [1:0] CALL = 2'd2;
    localparam logic [1:0] RET  = 2'd3;
    localparam logic [31:0] TOP_EMPTY = 32'h3FF;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_reg;
    logic [31:0] cmd_pc;
    logic        done;
    logic        err;
    logic [31:0] ret_pc;
    logic        readSP;
    logic [4:0]  sr2;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic        writeReg;
    logic [4:0]  dr;
    logic [31:0] write_data;
    logic        writeSP;
    logic [31:0] write_dataSP;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic        mem_re;
    logic [31:0] mem_rdata;

    stack_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_reg      (cmd_reg),
        .cmd_pc       (cmd_pc),
        .done         (done),
        .err          (err),
        .ret_pc       (ret_pc),
        .readSP       (readSP),
        .sr2          (sr2),
        .read_data1   (read_data1),
        .read_data2   (read_data2),
        .writeReg     (writeReg),
        .dr           (dr),
        .write_data   (write_data),
        .writeSP      (writeSP),
        .write_dataSP (write_dataSP),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_re       (mem_re),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    // Environment: register bank writes on negedge, memory on posedge
    bit [31:0] rb_sp;
    bit [31:0] rb_regs [32];
    bit [31:0] mem [1024];
    logic        set_sp_en = 1'b0;
    logic [31:0] set_sp_val = '0;
    logic        set_reg_en = 1'b0;
    logic [4:0]  set_reg_idx = '0;
    logic [31:0] set_reg_val = '0;
    logic        addr_oob = 1'b0;

    assign read_data1 = readSP ? rb_sp : 32'h0;
    assign read_data2 = rb_regs[sr2];

    always @(negedge clk) begin
        if (set_sp_en) rb_sp <= set_sp_val;
        else if (writeSP) rb_sp <= write_dataSP;
        if (set_reg_en) rb_regs[set_reg_idx] <= set_reg_val;
        else if (writeReg) rb_regs[dr] <= write_data;
    end

    always @(posedge clk) begin
        if ((mem_we || mem_re) && (mem_addr[31:10] != 22'h0)) addr_oob <= 1'b1;
        if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr[9:0]];
    end

    // Reference model state
    bit [31:0] ref_sp;
    bit [31:0] ref_regs [32];
    bit [31:0] ref_mem [1024];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_sp(input logic [31:0] v);
        @(posedge clk);
        set_sp_val = v;
        set_sp_en  = 1'b1;
        @(negedge clk);
        @(posedge clk);
        set_sp_en  = 1'b0;
    endtask

    task automatic set_reg(input logic [4:0] idx, input logic [31:0] v);
        @(posedge clk);
        set_reg_idx = idx;
        set_reg_val = v;
        set_reg_en  = 1'b1;
        @(negedge clk);
        @(posedge clk);
        set_reg_en  = 1'b0;
    endtask

    // Issue one command and check latency, error flag and resulting architectural state
    task automatic do_cmd(input logic [1:0] op, input logic [4:0] rg, input logic [31:0] pc,
                          input logic exp_err, input int exp_lat,
                          input logic [31:0] exp_sp, input logic [31:0] exp_val);
        logic got_done, got_err, busy_ready;
        logic seen_we, seen_re, seen_wsp, seen_wreg;
        int   lat;
        got_done = 1'b0; got_err = 1'b0; busy_ready = 1'b0; lat = 0;
        seen_we = 1'b0; seen_re = 1'b0; seen_wsp = 1'b0; seen_wreg = 1'b0;
        @(negedge clk);
        check("ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_reg = rg; cmd_pc = pc;
        @(posedge clk);
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 1) begin
                // Fields are don't-care after accept; valid may linger while busy
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_op    = 2'($urandom);
                cmd_reg   = 5'($urandom);
                cmd_pc    = $urandom;
            end
            seen_we   |= mem_we;
            seen_re   |= mem_re;
            seen_wsp  |= writeSP;
            seen_wreg |= writeReg;
            if (done) begin
                got_done = 1'b1;
                got_err  = err;
                lat      = n;
                break;
            end
            if (cmd_ready) busy_ready = 1'b1;
        end
        cmd_valid = 1'b0;
        check("done_seen", 32'(got_done), 32'd1);
        check("latency", 32'(lat), 32'(exp_lat));
        check("err_flag", 32'(got_err), 32'(exp_err));
        check("busy_not_ready", 32'(busy_ready), 32'd0);
        @(posedge clk);
        #1;
        check("sp_after", rb_sp, exp_sp);
        if (exp_err) begin
            check("err_no_strobes", {28'h0, seen_we, seen_re, seen_wsp, seen_wreg}, 32'h0);
        end else if (op == PUSH || op == CALL) begin
            check("push_no_read", 32'(seen_re), 32'd0);
            check("push_mem", mem[exp_sp[9:0]], exp_val);
        end else begin
            check("pop_wsp", 32'(seen_wsp), 32'd1);
            if (op == RET) begin
                check("ret_no_wreg", 32'(seen_wreg), 32'd0);
                check("ret_pc", ret_pc, exp_val);
            end else if (rg == 5'd0) begin
                check("r0_no_wreg", 32'(seen_wreg), 32'd0);
                check("r0_value", rb_regs[0], 32'h0);
            end else begin
                check("pop_reg", rb_regs[rg], exp_val);
            end
        end
    endtask

    // Abstract stack model: derive expectations, then run the command against them
    task automatic model_cmd(input logic [1:0] op, input logic [4:0] rg, input logic [31:0] pc);
        bit        is_push;
        bit        e;
        bit [31:0] val;
        is_push = (op == PUSH) || (op == CALL);
        e = is_push ? (ref_sp < 32'd1) : (ref_sp >= TOP_EMPTY);
        val = '0;
        if (!e) begin
            if (is_push) begin
                val = (op == CALL) ? pc : ((rg == 5'd0) ? 32'h0 : ref_regs[rg]);
                ref_sp = ref_sp - 1;
                ref_mem[ref_sp[9:0]] = val;
            end else begin
                val = ref_mem[ref_sp[9:0]];
                ref_sp = ref_sp + 1;
                if (op == POP && rg != 5'd0) ref_regs[rg] = val;
            end
        end
        do_cmd(op, rg, pc, e, (e || is_push) ? 2 : 3, ref_sp, val);
    endtask

    typedef struct {
        bit          set_sp;
        logic [31:0] sp0;
        logic [1:0]  op;
        logic [4:0]  rg;
        logic [31:0] pc;
        logic        exp_err;
        int          lat;
        logic [31:0] exp_sp;
        logic [31:0] exp_val;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 32'h3FF, PUSH, 5'd5, 32'h0,  1'b0, 2, 32'h3FE, 32'd5};
        tbl[1] = '{1'b0, 32'h0,   POP,  5'd7, 32'h0,  1'b0, 3, 32'h3FF, 32'd5};
        tbl[2] = '{1'b0, 32'h0,   CALL, 5'd0, 32'h40, 1'b0, 2, 32'h3FE, 32'h40};
        tbl[3] = '{1'b0, 32'h0,   RET,  5'd0, 32'h0,  1'b0, 3, 32'h3FF, 32'h40};
        tbl[4] = '{1'b0, 32'h0,   POP,  5'd7, 32'h0,  1'b1, 2, 32'h3FF, 32'h0};
        tbl[5] = '{1'b1, 32'h0,   PUSH, 5'd5, 32'h0,  1'b1, 2, 32'h0,   32'h0};
        tbl[6] = '{1'b1, 32'h1,   PUSH, 5'd5, 32'h0,  1'b0, 2, 32'h0,   32'd5};
        tbl[7] = '{1'b0, 32'h0,   POP,  5'd0, 32'h0,  1'b0, 3, 32'h1,   32'h0};
        tbl[8] = '{1'b1, 32'h3FE, POP,  5'd3, 32'h0,  1'b0, 3, 32'h3FF, 32'h40};

        reset = 1'b0;
        cmd_valid = 1'b0; cmd_op = '0; cmd_reg = '0; cmd_pc = '0;
        #1;
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_done_err", {30'h0, done, err}, 32'h0);
        check("rst_strobes", {27'h0, readSP, writeReg, writeSP, mem_we, mem_re}, 32'h0);
        check("rst_ret_pc", ret_pc, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Randomized ops against the model
        set_sp(TOP_EMPTY);
        ref_sp = TOP_EMPTY;
        for (int r = 1; r < 8; r++) begin
            ref_regs[r] = $urandom;
            set_reg(5'(r), ref_regs[r]);
        end
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 6))
                    0: ref_sp = 32'h0;
                    1: ref_sp = 32'h1;
                    2: ref_sp = 32'h2;
                    3: ref_sp = 32'h3FD;
                    4: ref_sp = 32'h3FE;
                    5: ref_sp = TOP_EMPTY;
                    default: ref_sp = 32'($urandom_range(0, 32'h3FF));
                endcase
                set_sp(ref_sp);
            end
            model_cmd(2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), $urandom);
        end

        // Directed vector table
        set_reg(5'd5, 32'd5);
        for (int v = 0; v < 9; v++) begin
            if (tbl[v].set_sp) set_sp(tbl[v].sp0);
            do_cmd(tbl[v].op, tbl[v].rg, tbl[v].pc, tbl[v].exp_err, tbl[v].lat,
                   tbl[v].exp_sp, tbl[v].exp_val);
        end

        // Reset while a POP sits in its memory-read cycle
        do_cmd(PUSH, 5'd5, 32'h0, 1'b0, 2, 32'h3FE, 32'd5);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = POP; cmd_reg = 5'd7; cmd_pc = '0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("abort_in_memrd", 32'(mem_re), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("abort_strobes", {25'h0, readSP, writeReg, writeSP, mem_we, mem_re, done, err}, 32'h0);
        check("abort_ready", 32'(cmd_ready), 32'd1);
        check("abort_ret_pc", ret_pc, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_sp", rb_sp, 32'h3FE);
        do_cmd(PUSH, 5'd5, 32'h0, 1'b0, 2, 32'h3FD, 32'd5);

        check("addr_in_range", 32'(addr_oob), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
